parallel_to_serial: RTL and testbench

Parallel-in, serial-out transmitter; the counterpart of the serial_to_parallel receiver. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, LSB-first by default. A one-word holding buffer lets consecutive words stream with no idle bit between frames. Sits on the transmit side of the same 1-bit serial link the receiver consumes.

---
 rtl/parallel_to_serial_if.sv | 34 +++
 rtl/parallel_to_serial.sv | 96 +++++++++
 tb/tb_parallel_to_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_if.sv
// Word-load handshake and serial link signals of the parallel-to-serial transmitter.
interface parallel_to_serial_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             busy;

    // Producer side: supplies words and watches the serial stream.
    modport master (
        output parallel_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_start,
        input  busy
    );

    // Transmitter side.
    modport slave (
        input  parallel_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output serial_valid,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/parallel_to_serial.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// back-to-back words stream out with no idle bit between frames.
//
// state | meaning
// IDLE  | nothing being shifted; serial_out held at 0
// SHIFT | a frame is on the wire; counter tracks the bit index
module parallel_to_serial #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    parallel_to_serial_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic [WIDTH-1:0] shifted;

    // Ready depends only on the hold flag, so there is no combinational path
    // from load_valid back to load_ready.
    assign accept  = bus.load_valid && !hold_full_q;

    // Zeros fill in behind the outgoing bit so nothing stale can reach the line.
    assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    // Next-state: frame sequencing, holding buffer and gapless reload on the last bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = bus.parallel_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = bus.parallel_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    hold_d      = bus.parallel_in;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight and drops the held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign bus.load_ready   = !hold_full_q;
    assign bus.serial_valid = (state_q == SHIFT);
    assign bus.serial_out   = (state_q == SHIFT) &&
                              (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign bus.frame_start  = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.busy         = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: single frames, streamed words,
// mid-frame reset, MSB-first order and a 32-bit loopback deserialised here.
module tb_parallel_to_serial;
    logic clk;
    logic rst;

    parallel_to_serial_if #(.WIDTH(4)) bus ();
    parallel_to_serial_if #(.WIDTH(4)) busm ();

    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (busm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  words_tx [8];
    logic [31:0] rx_bits;
    logic [31:0] fs_bits;
    int          rx_n;
    int          gaps;
    int          acc_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams words_tx[0..n-1] through the LSB-first DUT with load_valid held
    // high across stalls, logging every serial bit, frame_start and accept cycle.
    task automatic run_stream(input int n, input int budget, output bit done);
        int idx;
        bit started;
        bit acc;
        idx = 0; started = 0; done = 0;
        rx_bits = '0; fs_bits = '0; rx_n = 0; gaps = 0;
        acc_cyc.delete();
        bus.parallel_in = words_tx[0];
        bus.load_valid  = 1'b1;
        for (int c = 0; c < budget; c++) begin
            acc = bus.load_valid && bus.load_ready;
            tick();
            if (acc) begin
                acc_cyc.push_back(c);
                idx++;
                if (idx < n) bus.parallel_in = words_tx[idx];
                else begin
                    bus.load_valid  = 1'b0;
                    bus.parallel_in = '0;
                end
            end
            if (bus.serial_valid) begin
                if (rx_n < 32) begin
                    rx_bits[rx_n] = bus.serial_out;
                    fs_bits[rx_n] = bus.frame_start;
                end
                rx_n++;
                started = 1;
            end else if (started) begin
                if (idx >= n) begin
                    done = 1;
                    break;
                end
                gaps++;
            end
        end
        bus.load_valid = 1'b0;
    endtask

    initial begin
        bit done;
        int cnt;
        rst = 1'b0;
        bus.parallel_in  = '0; bus.load_valid  = 1'b0;
        busm.parallel_in = '0; busm.load_valid = 1'b0;
        #22;
        chk("rst_load_ready",   bus.load_ready,   1);
        chk("rst_serial_out",   bus.serial_out,   0);
        chk("rst_serial_valid", bus.serial_valid, 0);
        chk("rst_frame_start",  bus.frame_start,  0);
        chk("rst_busy",         bus.busy,         0);
        rst = 1'b1;
        tick();

        // single frame 4'b1011, LSB-first -> 1,1,0,1
        bus.parallel_in = 4'b1011; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.parallel_in = '0;
        chk("t1_b0", {bus.serial_valid, bus.frame_start, bus.serial_out}, 3'b111);
        tick();
        chk("t1_b1", {bus.serial_valid, bus.frame_start, bus.serial_out}, 3'b101);
        tick();
        chk("t1_b2", {bus.serial_valid, bus.frame_start, bus.serial_out}, 3'b100);
        tick();
        chk("t1_b3", {bus.serial_valid, bus.frame_start, bus.serial_out}, 3'b101);
        tick();
        chk("t1_idle", {bus.serial_valid, bus.serial_out, bus.busy}, 3'b000);
        tick();

        // A then 5 streamed: 0,1,0,1,1,0,1,0
        words_tx[0] = 4'hA; words_tx[1] = 4'h5;
        run_stream(2, 40, done);
        chk("t2_done",  done, 1);
        chk("t2_nbits", rx_n, 8);
        chk("t2_bits",  rx_bits[7:0], 8'h5A);
        chk("t2_fs",    fs_bits[7:0], 8'h11);
        chk("t2_gaps",  gaps, 0);
        tick();

        // 1,2,3 back-to-back: 1000 0100 1100, third accepted after the first last-bit edge
        words_tx[0] = 4'h1; words_tx[1] = 4'h2; words_tx[2] = 4'h3;
        run_stream(3, 60, done);
        chk("t3_done",  done, 1);
        chk("t3_nbits", rx_n, 12);
        chk("t3_bits",  rx_bits[11:0], 12'h321);
        chk("t3_fs",    fs_bits[11:0], 12'h111);
        chk("t3_gaps",  gaps, 0);
        chk("t3_acc0",  (acc_cyc.size() > 0) ? acc_cyc[0] : -1, 0);
        chk("t3_acc1",  (acc_cyc.size() > 1) ? acc_cyc[1] : -1, 1);
        chk("t3_acc2",  (acc_cyc.size() > 2) ? acc_cyc[2] : -1, 5);
        tick();

        // async reset mid-frame with the hold buffer full
        bus.parallel_in = 4'hF; bus.load_valid = 1'b1;
        tick();
        tick();
        bus.load_valid = 1'b0; bus.parallel_in = '0;
        chk("t4_pre_ready", bus.load_ready, 0);
        chk("t4_pre_busy",  bus.busy, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t4_rst_outs", {bus.serial_out, bus.serial_valid, bus.frame_start, bus.busy}, 4'b0000);
        chk("t4_rst_ready", bus.load_ready, 1);
        #2;
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.serial_valid || bus.serial_out) cnt++;
        end
        chk("t4_no_stale", cnt, 0);
        words_tx[0] = 4'h2;
        run_stream(1, 20, done);
        chk("t4_new_done", done, 1);
        chk("t4_new_bits", {rx_n[7:0], rx_bits[3:0]}, {8'd4, 4'h2});
        tick();

        // MSB-first 4'b1011 -> 1,0,1,1
        busm.parallel_in = 4'b1011; busm.load_valid = 1'b1;
        tick();
        busm.load_valid = 1'b0; busm.parallel_in = '0;
        chk("t5_b0", {busm.serial_valid, busm.frame_start, busm.serial_out}, 3'b111);
        tick();
        chk("t5_b1", {busm.serial_valid, busm.frame_start, busm.serial_out}, 3'b100);
        tick();
        chk("t5_b2", {busm.serial_valid, busm.frame_start, busm.serial_out}, 3'b101);
        tick();
        chk("t5_b3", {busm.serial_valid, busm.frame_start, busm.serial_out}, 3'b101);
        tick();
        chk("t5_idle", {busm.serial_valid, busm.serial_out, busm.busy}, 3'b000);

        // loopback: 8 words, 32 bits, regrouped into words at the receiving end
        words_tx[0] = 4'h9; words_tx[1] = 4'h6; words_tx[2] = 4'hF; words_tx[3] = 4'h0;
        words_tx[4] = 4'hC; words_tx[5] = 4'h3; words_tx[6] = 4'h7; words_tx[7] = 4'hE;
        run_stream(8, 80, done);
        chk("t6_done",  done, 1);
        chk("t6_nbits", rx_n, 32);
        chk("t6_fs",    fs_bits, 32'h1111_1111);
        chk("t6_gaps",  gaps, 0);
        chk("t6_rx_stream", rx_bits, 32'hE73C_0F69);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t6_word%0d", k), rx_bits[4*k +: 4], words_tx[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
